// File: rtl/std_mem_d1_arb_pkg.sv
// Shared types and helpers for the std_mem_d1 round-robin arbiter.
// Optional bounds checking is enabled by STD_MEM_D1_ARB_BOUNDS_CHECK_EN.
package std_mem_d1_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int RIDX_W  = 3;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_DONE
  } state_e;

  function automatic logic [RIDX_W-1:0] oh2idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [RIDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx |= RIDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/std_mem_d1_arbiter_if.sv
// Requester-side request/response bundle of the std_mem_d1 arbiter.
// The arbiter is the slave; the requesters form the master side.
interface std_mem_d1_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4,
  parameter int NUM_REQ  = 2
) ();

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_we;
  logic [NUM_REQ*IDX_SIZE-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]    req_wdata;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [WIDTH-1:0]            rsp_rdata;
  logic                        rsp_err;
  logic                        busy;

  modport slave (
    input  req_valid, req_we,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err, busy
  );

  modport master (
    output req_valid, req_we,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/std_mem_d1_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first request at or above ptr_i,
// wrapping modulo N; en_i low suppresses every grant.
module rr_arbiter
  import std_mem_d1_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]      req_i,
  input  logic [RIDX_W-1:0] ptr_i,
  input  logic              en_i,
  output logic [N-1:0]      grant_o,
  output logic [RIDX_W-1:0] grant_idx_o
);

  int   pos;
  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos -= N;
      for (int j = 0; j < N; j++) begin
        if (!found && en_i && req_i[j] && pos == j) begin
          grant_o[j] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  assign grant_idx_o = oh2idx(MAX_REQ'(grant_o));

endmodule

// File: rtl/std_mem_d1_arbiter.sv
// Round-robin sharing of one single-port std_mem_d1 among NUM_REQ requesters.
// Define STD_MEM_D1_ARB_BOUNDS_CHECK_EN to reject addresses >= SIZE.
module std_mem_d1_arbiter
  import std_mem_d1_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4,
  parameter int NUM_REQ  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  std_mem_d1_arbiter_if.slave req_if,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_write_data,
  output logic                mem_write_en,
  input  logic [WIDTH-1:0]    mem_read_data,
  input  logic                mem_done
);

  localparam logic [RIDX_W-1:0] LAST = RIDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ ||
      SIZE > (1 << IDX_SIZE)) begin : g_bad_cfg
    $error("std_mem_d1_arbiter: bad parameters");
  end

  state_e              state_q, state_d;
  logic [RIDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [IDX_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [NUM_REQ-1:0]  wr_oh_q, wr_oh_d;

  logic [NUM_REQ-1:0]  grant;
  logic [RIDX_W-1:0]   grant_idx;
  logic [RIDX_W-1:0]   ptr_nxt;
  logic                arb_en;
  logic                accept;
  logic                g_we;
  logic                g_err;
  logic [IDX_SIZE-1:0] g_addr;
  logic [WIDTH-1:0]    g_wdata;

  assign arb_en = reset_n && (state_q == IDLE);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i       (req_if.req_valid),
    .ptr_i       (rr_ptr_q),
    .en_i        (arb_en),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign accept  = |grant;
  assign g_we    = |(req_if.req_we & grant);
  assign ptr_nxt = (grant_idx == LAST) ? '0
                 : grant_idx + 1'b1;

  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_addr  = req_if.req_addr[i*IDX_SIZE +: IDX_SIZE];
        g_wdata = req_if.req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef STD_MEM_D1_ARB_BOUNDS_CHECK_EN
  localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE+1)'(SIZE);
  assign g_err = ({1'b0, g_addr} >= SIZE_W);
`else
  assign g_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    rsp_valid_d    = '0;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    wr_oh_d        = wr_oh_q;
    mem_addr0      = g_addr;
    mem_write_data = g_wdata;
    mem_write_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rr_ptr_d = ptr_nxt;
          // rejected accesses answer at once and never touch memory
          if (g_err) begin
            rsp_valid_d = grant;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (g_we) begin
            mem_write_en = 1'b1;
            state_d      = WAIT_DONE;
            wr_addr_d    = g_addr;
            wr_data_d    = g_wdata;
            wr_oh_d      = grant;
          end else begin
            rsp_valid_d = grant;
            rsp_rdata_d = mem_read_data;
          end
        end
      end
      WAIT_DONE: begin
        mem_addr0      = wr_addr_q;
        mem_write_data = wr_data_q;
        if (mem_done) begin
          rsp_valid_d = wr_oh_q;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_oh_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_oh_q     <= wr_oh_d;
    end
  end

  assign req_if.req_ready = grant;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rsp_rdata_q;
  assign req_if.rsp_err   = rsp_err_q;
  assign req_if.busy      = (state_q == WAIT_DONE);

endmodule

// File: tb/tb_std_mem_d1_arbiter.sv
// Bench for std_mem_d1_arbiter: per-cycle vector table plus response queue.
// Define STD_MEM_D1_ARB_BOUNDS_CHECK_EN to also exercise bounds rejection.
module tb_std_mem_d1_arbiter;

  localparam int WIDTH = 32;
  localparam int IDX   = 4;
  localparam int NR    = 2;
`ifdef STD_MEM_D1_ARB_BOUNDS_CHECK_EN
  localparam int SIZE  = 12;
  localparam bit BCHK  = 1'b1;
`else
  localparam int SIZE  = 16;
  localparam bit BCHK  = 1'b0;
`endif

  typedef struct {
    bit          rst;
    logic [1:0]  vld;
    logic [1:0]  we;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          done;
    logic [1:0]  rdy;
    bit          wen;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [1:0]  oh;
    logic [31:0] data;
    bit          is_rd;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [IDX-1:0]   mem_addr0;
  logic [WIDTH-1:0] mem_write_data;
  logic             mem_write_en;
  logic [WIDTH-1:0] mem_read_data;
  logic             mem_done;

  std_mem_d1_arbiter_if #(
    .WIDTH(WIDTH), .IDX_SIZE(IDX), .NUM_REQ(NR)
  ) bus ();

  std_mem_d1_arbiter #(
    .WIDTH(WIDTH), .SIZE(SIZE),
    .IDX_SIZE(IDX), .NUM_REQ(NR)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_if         (bus),
    .mem_addr0      (mem_addr0),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .mem_done       (mem_done)
  );

  // memory model: combinational read, registered write
  logic [WIDTH-1:0] mem [16];
  assign mem_read_data = mem[mem_addr0];
  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 32'hA5A5_0000 | k;
    forever begin
      @(posedge clk);
      if (mem_write_en) mem[mem_addr0] <= mem_write_data;
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        sb[$];
  vec_t        tbl[$];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_last;
  bit          pend;
  logic [1:0]  pend_oh;
  logic [3:0]  pend_addr;
  logic [31:0] pend_data;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input bit rst, input logic [1:0] vld,
    input logic [1:0] we, input logic [3:0] a0,
    input logic [3:0] a1, input logic [31:0] d0,
    input logic [31:0] d1, input bit done,
    input logic [1:0] rdy, input bit wen);
    vec_t v;
    v.rst = rst;  v.vld = vld; v.we = we;
    v.a0 = a0;    v.a1 = a1;   v.d0 = d0;
    v.d1 = d1;    v.done = done;
    v.rdy = rdy;  v.wen = wen;
    return v;
  endfunction

  function automatic vec_t idle(input bit done);
    return mk(0, 2'b00, 2'b00, 0, 0, 0, 0, done, 2'b00, 0);
  endfunction

  task automatic apply(input vec_t v);
    exp_t        e;
    bit          g;
    logic [3:0]  a;
    logic [31:0] d;
    bit          err;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(e.oh));
      chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
      if (e.is_rd) exp_last = e.data;
    end else begin
      chk("rsp_quiet", 64'(bus.rsp_valid), 64'(0));
    end
    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_last));
    chk("busy", 64'(bus.busy), 64'(pend));
    reset_n       = !v.rst;
    bus.req_valid = v.vld;
    bus.req_we    = v.we;
    bus.req_addr  = {v.a1, v.a0};
    bus.req_wdata = {v.d1, v.d0};
    mem_done      = v.done;
    #1;
    chk("req_ready", 64'(bus.req_ready), 64'(v.rdy));
    chk("mem_write_en", 64'(mem_write_en), 64'(v.wen));
    if (pend) begin
      chk("hold_addr", 64'(mem_addr0), 64'(pend_addr));
      chk("hold_data", 64'(mem_write_data), 64'(pend_data));
    end
    if (v.rst) begin
      pend     = 1'b0;
      exp_last = '0;
    end else if (pend && v.done) begin
      sb.push_back('{cyc + 1, pend_oh, 32'h0, 1'b0, 1'b0});
      pend = 1'b0;
    end
    if (v.rdy != 2'b00) begin
      g   = v.rdy[1];
      a   = g ? v.a1 : v.a0;
      d   = g ? v.d1 : v.d0;
      err = BCHK && (int'(a) >= SIZE);
      chk("mem_addr0", 64'(mem_addr0), 64'(a));
      if (err) begin
        sb.push_back('{cyc + 1, v.rdy, 32'h0, 1'b1, 1'b1});
      end else if (v.we[g]) begin
        chk("mem_wdata", 64'(mem_write_data), 64'(d));
        ref_mem[a] = d;
        pend       = 1'b1;
        pend_oh    = v.rdy;
        pend_addr  = a;
        pend_data  = d;
      end else begin
        sb.push_back('{cyc + 1, v.rdy, ref_mem[a], 1'b1, 1'b0});
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) ref_mem[k] = 32'hA5A5_0000 | k;
    exp_last      = '0;
    pend          = 1'b0;
    pend_oh       = '0;
    pend_addr     = '0;
    pend_data     = '0;
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    mem_done      = 1'b0;
    repeat (2) @(posedge clk);

    // reset forces ready low even with requests pending
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    // write then read of the same word
    tbl.push_back(idle(0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 3, 0, 32'hDEADBEEF, 0, 0, 2'b01, 1));
    tbl.push_back(idle(1));
    tbl.push_back(mk(0, 2'b10, 2'b00, 0, 3, 0, 0, 0, 2'b10, 0));
    tbl.push_back(idle(0));
    // contending reads alternate
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 2'b11, 2'b00, 3, 5, 0, 0, 0,
                       (i % 2 == 0) ? 2'b01 : 2'b10, 0));
    // read by req1 stalls behind req0 write
    tbl.push_back(mk(0, 2'b11, 2'b01, 7, 3, 32'h12345678, 0, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b10, 2'b00, 7, 3, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 0, 3, 0, 0, 1, 2'b00, 0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 0, 3, 0, 0, 0, 2'b10, 0));
    tbl.push_back(idle(0));
    // reset inside WAIT_DONE, stray done, pointer back at 0
    tbl.push_back(mk(0, 2'b01, 2'b01, 9, 0, 32'hCAFEF00D, 0, 0, 2'b01, 1));
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 9, 0, 0, 0, 0, 2'b01, 0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b10, 0));
    // single requester streams reads of a fresh value
    tbl.push_back(mk(0, 2'b01, 2'b01, 0, 0, 32'h0BADC0DE, 0, 0, 2'b01, 1));
    tbl.push_back(idle(1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b01, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // long WAIT_DONE with req0 pending
    apply(mk(0, 2'b10, 2'b10, 0, 6, 0, 32'h600D600D, 0, 2'b10, 1));
    for (int i = 0; i < 5; i++)
      apply(mk(0, 2'b01, 2'b00, 6, 0, 0, 0, 0, 2'b00, 0));
    apply(mk(0, 2'b01, 2'b00, 6, 0, 0, 0, 1, 2'b00, 0));
    apply(mk(0, 2'b01, 2'b00, 6, 0, 0, 0, 0, 2'b01, 0));
    apply(idle(0));

`ifdef STD_MEM_D1_ARB_BOUNDS_CHECK_EN
    apply(mk(0, 2'b01, 2'b00, 15, 0, 0, 0, 0, 2'b01, 0));
    apply(mk(0, 2'b01, 2'b01, 14, 0, 32'h11112222, 0, 0, 2'b01, 0));
    apply(mk(0, 2'b01, 2'b00, 14, 0, 0, 0, 0, 2'b01, 0));
    apply(mk(0, 2'b10, 2'b00, 0, 3, 0, 0, 0, 2'b10, 0));
    apply(idle(0));
`endif

    repeat (3) apply(idle(0));
    chk("sb_drain", 64'(sb.size()), 64'(0));
    chk("mem_14_untouched", 64'(mem[14]), 64'(ref_mem[14]));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
